// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module branch_target_buffer #(
  parameter int ENTRIES     = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lookup_pc,
  output logic        o_predict_taken,
  output logic [31:0] o_predict_target,
  input  logic        i_update_valid,
  input  logic [31:0] i_update_pc,
  input  logic        i_update_taken,
  input  logic [31:0] i_update_target,
  input  logic        i_flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] o_update_count,
  output logic [31:0] o_mispredict_count
`endif
);

  localparam int TAG_W = 32 - INDEX_WIDTH - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [INDEX_WIDTH-1:0] w_lk_idx;
  logic [TAG_W-1:0]       w_lk_tag;
  logic                   w_lk_hit;
  logic [INDEX_WIDTH-1:0] w_up_idx;
  logic [TAG_W-1:0]       w_up_tag;
  logic                   w_up_hit;
  logic                   w_up_accept;
  logic                   w_unused;

  // PC[1:0] never participates in indexing or tagging.
  assign w_unused = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

  assign w_lk_idx = i_lookup_pc[INDEX_WIDTH+1:2];
  assign w_lk_tag = i_lookup_pc[31:INDEX_WIDTH+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign o_predict_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign o_predict_target = w_lk_hit ? r_target[w_lk_idx] : 32'd0;

  assign w_up_idx    = i_update_pc[INDEX_WIDTH+1:2];
  assign w_up_tag    = i_update_pc[31:INDEX_WIDTH+2];
  assign w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_accept = i_update_valid && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (i_flush) begin
      // Flush drops only the valid bits; any same-cycle update is discarded.
      r_valid <= '0;
    end else if (i_update_valid) begin
      if (w_up_hit) begin
        if (i_update_taken) begin
          r_target[w_up_idx] <= i_update_target;
          if (r_ctr[w_up_idx] != 2'b11) begin
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
          end
        end else if (r_ctr[w_up_idx] != 2'b00) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end else if (i_update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= i_update_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic w_up_pred_dir;
  logic w_up_mispredict;

  assign w_up_pred_dir   = w_up_hit && r_ctr[w_up_idx][1];
  assign w_up_mispredict = (w_up_pred_dir != i_update_taken) ||
                           (i_update_taken && w_up_hit &&
                            (r_target[w_up_idx] != i_update_target));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_update_count     <= '0;
      o_mispredict_count <= '0;
    end else if (w_up_accept) begin
      o_update_count <= o_update_count + 32'd1;
      if (w_up_mispredict) begin
        o_mispredict_count <= o_mispredict_count + 32'd1;
      end
    end
  end
`else
  logic w_unused_accept;
  assign w_unused_accept = w_up_accept;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized bench for branch_target_buffer against an array-based table model,
// with directed checks for the basic learn/alias/flush/reset scenarios.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int IW      = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        flush;
`ifdef BTB_STATS_EN
  logic [31:0] update_count;
  logic [31:0] mispredict_count;
`endif

  int n_tests;
  int n_fail;

  // Reference table: plain ints, counter kept as a number 0..3.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int unsigned m_upd_cnt;
  int unsigned m_mis_cnt;

  branch_target_buffer #(.ENTRIES(ENTRIES), .INDEX_WIDTH(IW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_lookup_pc      (lookup_pc),
    .o_predict_taken  (predict_taken),
    .o_predict_target (predict_target),
    .i_update_valid   (update_valid),
    .i_update_pc      (update_pc),
    .i_update_taken   (update_taken),
    .i_update_target  (update_target),
    .i_flush          (flush)
`ifdef BTB_STATS_EN
    ,
    .o_update_count     (update_count),
    .o_mispredict_count (mispredict_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input int unsigned pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned m_tg(input int unsigned pc);
    return pc >> (IW + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
    end
    m_upd_cnt = 0;
    m_mis_cnt = 0;
  endtask

  task automatic model_lookup(input int unsigned pc, output bit hit, output bit tk,
                              output int unsigned tgt);
    int i;
    i   = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tg(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = hit ? m_target[i] : 0;
  endtask

  task automatic model_update(input bit uv, input int unsigned pc, input bit tk,
                              input int unsigned tgt, input bit fl);
    bit hit, pdir;
    int unsigned ptgt;
    int i;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      return;
    end
    if (!uv) return;
    i = m_idx(pc);
    model_lookup(pc, hit, pdir, ptgt);
    m_upd_cnt++;
    if ((pdir != tk) || (tk && hit && ptgt != tgt)) m_mis_cnt++;
    if (hit) begin
      if (tk) begin
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = m_tg(pc); m_target[i] = tgt; m_ctr[i] = 2;
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic do_cycle(input bit uv, input int unsigned upc, input bit ut,
                          input int unsigned utgt, input bit fl, input int unsigned lpc);
    bit hit, tk;
    int unsigned tgt;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    flush         = fl;
    lookup_pc     = lpc;
    #4;
    model_lookup(lpc, hit, tk, tgt);
    check_eq("lookup_taken", {31'd0, predict_taken}, {31'd0, tk});
    check_eq("lookup_target", predict_target, tgt);
    @(posedge clk);
    model_update(uv, upc, ut, utgt, fl);
    #1;
    update_valid = 1'b0;
    flush        = 1'b0;
`ifdef BTB_STATS_EN
    check_eq("update_count", update_count, m_upd_cnt);
    check_eq("mispredict_count", mispredict_count, m_mis_cnt);
`endif
  endtask

  task automatic peek(input string tag, input int unsigned pc, input bit exp_tk,
                      input int unsigned exp_tgt);
    lookup_pc = pc;
    #1;
    check_eq({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_tk});
    check_eq({tag, "_target"}, predict_target, exp_tgt);
  endtask

  initial begin
    int unsigned upc, utgt, lpc;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; flush = 1'b0; lookup_pc = 32'h100;
    model_reset();
    #2;
    check_eq("reset_taken", {31'd0, predict_taken}, 32'd0);
    check_eq("reset_target", predict_target, 32'd0);
`ifdef BTB_STATS_EN
    check_eq("reset_upd_cnt", update_count, 32'd0);
    check_eq("reset_mis_cnt", mispredict_count, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_cycle(1, 32'h100, 1, 32'h200, 0, 32'h100);
    peek("alloc", 32'h100, 1, 32'h200);
    do_cycle(1, 32'h100, 0, 0, 0, 32'h100);
    peek("ctr01", 32'h100, 0, 32'h200);
    do_cycle(1, 32'h100, 0, 0, 0, 32'h100);
    peek("ctr00", 32'h100, 0, 32'h200);
    do_cycle(1, 32'h100, 1, 32'h200, 0, 32'h100);
    peek("ctr01_up", 32'h100, 0, 32'h200);
    do_cycle(1, 32'h100, 1, 32'h200, 0, 32'h100);
    peek("ctr10_up", 32'h100, 1, 32'h200);
    do_cycle(1, 32'h140, 1, 32'h300, 0, 32'h140);
    peek("alias_old", 32'h100, 0, 32'h0);
    peek("alias_new", 32'h140, 1, 32'h300);
    do_cycle(1, 32'h180, 1, 32'h400, 1, 32'h180);
    peek("flush_old", 32'h140, 0, 32'h0);
    peek("flush_upd", 32'h180, 0, 32'h0);
    do_cycle(1, 32'h140, 1, 32'h300, 0, 32'h140);

    // Asynchronous reset between edges with a live hit on the lookup port.
    lookup_pc = 32'h140;
    #2;
    check_eq("pre_rst_taken", {31'd0, predict_taken}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_taken", {31'd0, predict_taken}, 32'd0);
    check_eq("async_rst_target", predict_target, 32'd0);
`ifdef BTB_STATS_EN
    check_eq("async_rst_upd_cnt", update_count, 32'd0);
    check_eq("async_rst_mis_cnt", mispredict_count, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Small tag/target pools force frequent hits, aliases and target changes.
    for (int n = 0; n < 1500; n++) begin
      upc  = (32'(($urandom_range(0, 3))) << 6) | (32'($urandom_range(0, 15)) << 2) |
             32'($urandom_range(0, 3));
      utgt = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
      lpc  = ($urandom_range(0, 1) == 0) ? upc :
             ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
      do_cycle($urandom_range(0, 3) != 0, upc, $urandom_range(0, 2) != 0, utgt,
               $urandom_range(0, 39) == 0, lpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
